intr_ctrl_n: RTL and testbench

Parametrised N-source interrupt controller. Replaces the fixed two-line timer/external interrupt capture in the pipelined core with a memory-mapped block on the peripheral bus. Synchronises, edge- or level-qualifies, masks and prioritises N_SRC request lines, then drives a single request plus source ID into the core's CSR/trap path. The block tracks claim (trap taken) and completion (mret) so only one interrupt is in service at a time.

---
 rtl/intr_ctrl_n.sv | 199 +++++++++++++++++++
 tb/tb_intr_ctrl_n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl_n.sv
// intr_ctrl_n: N-source interrupt controller on the peripheral bus.
//
// Synchronises N_SRC raw request lines, qualifies each as rising-edge or level,
// masks them with ENABLE, picks a winner and presents one request plus source ID
// to the core. Claim (trap taken) and mret complete the handshake so only one
// interrupt is ever in service.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   src_i               raw interrupt lines (asynchronous)
//   cs_i, we_i, addr_i  bus select, write strobe, byte address (addr_i[3:2] = reg)
//   wdata_i, rdata_o    bus write data, combinational read data
//   irq_o, irq_id_o     request to the core and ID of requesting/in-service source
//   claim_i, mret_i     trap-taken and mret-retired strobes from the core
//
// Register map: 0 ENABLE (rw), 1 PENDING (r, W1C edge bits), 2 MODE (rw, 1 = edge),
//               3 CLAIM (r: bit DW-1 = busy, [IDW-1:0] = ID).
//
// Optional macro INTR_PRIO_ROTATE_EN: round-robin arbitration starting after the
// last claimed ID. Undefined: fixed lowest-index priority.
module intr_ctrl_n #(
  parameter int unsigned DW    = 32,
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ADDRW = 4,
  localparam int unsigned IDW  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o,
  output logic             irq_o,
  output logic [IDW-1:0]   irq_id_o,
  input  logic             claim_i,
  input  logic             mret_i
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  logic [N_SRC-1:0] sync1_q, sync2_q, hist_q;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   win_id;

  logic             wr_en, rd_en, claim_take;
  logic [1:0]       reg_sel;
  logic [N_SRC-1:0] rise, elig, w1c, claim_clr;

  // Only addr_i[3:2] and wdata_i[N_SRC-1:0] carry meaning.
  logic unused_bits;
  assign unused_bits = ^{addr_i, wdata_i};

  assign wr_en   = cs_i & we_i;
  assign rd_en   = cs_i & ~we_i;
  assign reg_sel = addr_i[3:2];

  assign rise       = sync2_q & ~hist_q;
  assign elig       = pend_q & enable_q;
  assign claim_take = (state_q == StReq) && claim_i;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef INTR_PRIO_ROTATE_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  assign ptr_d = claim_take ? id_q : ptr_q;

  // Walk offsets from farthest to nearest so the nearest eligible index after
  // the pointer is the last one written.
  always_comb begin
    win_id = '0;
    for (int k = int'(N_SRC); k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(N_SRC);
      if (elig[idx]) win_id = IDW'(idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Descending scan: the lowest eligible index is written last and wins.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) win_id = IDW'(i);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    if (wr_en) begin
      case (reg_sel)
        2'd0:    enable_d = wdata_i[N_SRC-1:0];
        2'd1:    w1c      = wdata_i[N_SRC-1:0];
        2'd2:    mode_d   = wdata_i[N_SRC-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      claim_clr[i] = claim_take && (id_q == IDW'(i));
    end
  end

  // Edge bits: a new rising edge beats a same-cycle clear. Level bits simply
  // follow the synchronised line, so W1C and claim do nothing to them.
  assign pend_d = (mode_q & ((pend_q & ~(w1c | claim_clr)) | rise)) |
                  (~mode_q & sync2_q);

  // ---------------------------------------------------------------------------
  // Service FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d = StReq;
          id_d    = win_id;
        end
      end
      StReq: begin
        // ID is frozen here; a withdrawn request falls back to idle.
        if (claim_i)           state_d = StActive;
        else if (!elig[id_q])  state_d = StIdle;
      end
      StActive: begin
        if (mret_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      state_q  <= StIdle;
      id_q     <= '0;
    end else begin
      sync1_q  <= src_i;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      id_q     <= id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign irq_o    = (state_q == StReq);
  assign irq_id_o = id_q;

  always_comb begin
    rdata_o = '0;
    if (rd_en) begin
      case (reg_sel)
        2'd0: rdata_o[N_SRC-1:0] = enable_q;
        2'd1: rdata_o[N_SRC-1:0] = pend_q;
        2'd2: rdata_o[N_SRC-1:0] = mode_q;
        default: begin
          rdata_o[DW-1]    = (state_q != StIdle);
          rdata_o[IDW-1:0] = id_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Directed bench for intr_ctrl_n (N_SRC = 8, DW = 32).
module tb_intr_ctrl_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        cs, we, claim, mret;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata, rv;
  logic        irq;
  logic [2:0]  irq_id;

  int total = 0;
  int bad   = 0;

  intr_ctrl_n #(.DW(32), .N_SRC(8), .ADDRW(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .src_i    (src),
    .cs_i     (cs),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .irq_o    (irq),
    .irq_id_o (irq_id),
    .claim_i  (claim),
    .mret_i   (mret)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] idx, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = {idx, 2'b00}; wdata = d;
    tick(1);
    cs = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [1:0] idx, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = {idx, 2'b00};
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic pulse_claim();
    claim = 1'b1; tick(1); claim = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; tick(1); mret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(1); rst = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    for (int r = 0; r < 4; r++) begin
      bus_rd(2'(r), rv);
      total++;
      if (rv !== 32'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0", r, rv); end
    end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_idle: got %h want 0", rdata); end
  endtask

  task automatic test_regs();
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_rd(2'd0, rv);
    total++; if (rv !== 32'h0000_00FF) begin bad++; $display("FAIL en_mask: got %h want ff", rv); end
    bus_wr(2'd2, 32'h1234_56A5);
    bus_rd(2'd2, rv);
    total++; if (rv !== 32'h0000_00A5) begin bad++; $display("FAIL mode_rw: got %h want a5", rv); end
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd2, 32'h0);
  endtask

  task automatic test_edge_request();
    bus_wr(2'd2, 32'h01);
    bus_wr(2'd0, 32'h01);
    src[0] = 1'b1; tick(1); src[0] = 1'b0;
    tick(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_early: got %b want 0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL edge_irq: got %b want 1", irq); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL edge_id: got %0d want 0", irq_id); end
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h8000_0000) begin bad++; $display("FAIL edge_claimreg: got %h want 80000000", rv); end
  endtask

  task automatic test_claim_mret();
    pulse_claim();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL claim_irq: got %b want 0", irq); end
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL claim_pend: got %h want 0", rv); end
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h8000_0000) begin bad++; $display("FAIL active_claimreg: got %h want 80000000", rv); end
    pulse_mret();
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL mret_claimreg: got %h want 0", rv); end
    tick(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mret_quiet: got %b want 0", irq); end
  endtask

  task automatic test_level_drop();
    bus_wr(2'd0, 32'h08);
    src[3] = 1'b1;
    tick(4);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq: got %b want 1", irq); end
    total++; if (irq_id !== 3'd3) begin bad++; $display("FAIL lvl_id: got %0d want 3", irq_id); end
    src[3] = 1'b0;
    tick(2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_hold: got %b want 1", irq); end
    tick(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_drop: got %b want 0", irq); end
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h0000_0003) begin bad++; $display("FAIL lvl_idle: got %h want 3", rv); end
  endtask

  task automatic test_priority();
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd2, 32'h24);
    src = 8'h24; tick(1); src = 8'h00;
    tick(3);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h24) begin bad++; $display("FAIL prio_pend: got %h want 24", rv); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_masked: got %b want 0", irq); end
    bus_wr(2'd0, 32'h24);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_en0: got %b want 0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_en1: got %b want 1", irq); end
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL prio_first: got %0d want 2", irq_id); end
    pulse_claim();
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h20) begin bad++; $display("FAIL prio_pend2: got %h want 20", rv); end
    pulse_mret();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_idle: got %b want 0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL b2b_irq: got %b want 1", irq); end
    total++; if (irq_id !== 3'd5) begin bad++; $display("FAIL b2b_id: got %0d want 5", irq_id); end
    pulse_claim();
    pulse_mret();
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL prio_drained: got %h want 0", rv); end
`ifdef INTR_PRIO_ROTATE_EN
    // Serve source 2 alone so the last-served pointer becomes 2.
    src = 8'h04; tick(1); src = 8'h00;
    tick(3);
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL rr_setup: got %0d want 2", irq_id); end
    pulse_claim();
    pulse_mret();
    bus_wr(2'd0, 32'h0);
    src = 8'h24; tick(1); src = 8'h00;
    tick(3);
    bus_wr(2'd0, 32'h24);
    tick(1);
    total++; if (irq_id !== 3'd5) begin bad++; $display("FAIL rr_first: got %0d want 5", irq_id); end
    pulse_claim();
    pulse_mret();
    tick(1);
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL rr_second: got %0d want 2", irq_id); end
    pulse_claim();
    pulse_mret();
`endif
  endtask

  task automatic test_w1c();
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd2, 32'h02);
    src[1] = 1'b1; tick(1); src[1] = 1'b0;
    tick(3);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h02) begin bad++; $display("FAIL w1c_setup: got %h want 02", rv); end
    // Second edge reaches the pending register on the same edge as the W1C.
    src[1] = 1'b1; tick(1); src[1] = 1'b0;
    tick(1);
    bus_wr(2'd1, 32'h02);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h02) begin bad++; $display("FAIL w1c_collide: got %h want 02", rv); end
    bus_wr(2'd1, 32'h02);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want 0", rv); end
    src[3] = 1'b1;
    tick(3);
    bus_wr(2'd1, 32'h08);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h08) begin bad++; $display("FAIL w1c_level: got %h want 08", rv); end
    src[3] = 1'b0;
    tick(4);
    bus_rd(2'd1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL w1c_lvlfall: got %h want 0", rv); end
  endtask

  task automatic test_reset_active();
    bus_wr(2'd2, 32'h10);
    bus_wr(2'd0, 32'h10);
    src[4] = 1'b1; tick(1); src[4] = 1'b0;
    tick(3);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ra_irq: got %b want 1", irq); end
    pulse_claim();
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h8000_0004) begin bad++; $display("FAIL ra_active: got %h want 80000004", rv); end
    rst = 1'b1; tick(1); rst = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ra_irq0: got %b want 0", irq); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL ra_id0: got %0d want 0", irq_id); end
    for (int r = 0; r < 4; r++) begin
      bus_rd(2'(r), rv);
      total++;
      if (rv !== 32'h0) begin bad++; $display("FAIL ra_reg%0d: got %h want 0", r, rv); end
    end
    pulse_claim();
    pulse_mret();
    tick(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL stray_irq: got %b want 0", irq); end
    bus_rd(2'd3, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL stray_claimreg: got %h want 0", rv); end
  endtask

  initial begin
    rst = 1'b1; src = '0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    claim = 1'b0; mret = 1'b0;
    tick(2);
    test_reset();
    test_regs();
    test_edge_request();
    test_claim_mret();
    test_level_drop();
    test_priority();
    test_w1c();
    test_reset_active();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
